seq_muldiv_unit: RTL and testbench

SEQ_MULDIV_UNIT -- requirements
Module: seq_muldiv_unit

---
 rtl/seq_muldiv_unit.sv | 83 ++++++++
 tb/tb_seq_muldiv_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: 32-cycle radix-2 unsigned multiply/divide unit with register-file writeback.
module seq_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_register,
  output logic             busy,
  output logic             done,
  output logic             reg_write,
  output logic [4:0]       write_register,
  output logic [WIDTH-1:0] write_data,
  output logic             div_by_zero
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0]       r_state;
  logic [4:0]       r_cnt;
  logic [1:0]       r_op;
  logic [4:0]       r_dest;
  logic [WIDTH-1:0] r_x, r_y, r_acc;
  logic             w_div, w_ge;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_acc_nxt, w_res;
  // r_x: multiplicand (mul) or dividend shifting into quotient (div); r_acc: product or remainder
  assign w_div     = r_op == 2'b01 || r_op == 2'b10;
  assign w_rem_sh  = {r_acc, r_x[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_y};
  assign w_ge      = !w_diff[WIDTH];
  assign w_acc_nxt = w_div ? (w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0])
                           : r_acc + (r_y[0] ? r_x : '0);
  assign w_x_nxt   = w_div ? {r_x[WIDTH-2:0], w_ge} : r_x << 1;
  assign w_y_nxt   = w_div ? r_y : r_y >> 1;
  assign w_res     = r_op == 2'b01 ? w_x_nxt : w_acc_nxt;
  assign busy      = r_state == S_RUN;
  assign done      = r_state == S_DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op           <= '0;
      r_dest         <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_acc          <= '0;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      div_by_zero    <= 1'b0;
    end else begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      div_by_zero    <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_op    <= op;
        r_dest  <= dest_register;
        r_x     <= operand_a;
        r_y     <= operand_b;
        r_acc   <= '0;
      end else if (r_state == S_RUN) begin
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_state        <= S_DONE;
          reg_write      <= r_dest != 5'd0;
          write_register <= r_dest;
          write_data     <= w_res;
          div_by_zero    <= w_div && r_y == '0;
        end
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed vector table plus start-hold, reset-abort and back-to-back sequences.
module tb_seq_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  dest_register = '0;
  logic        busy, done, reg_write, div_by_zero;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  int checks = 0, errors = 0;

  seq_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .operand_a(operand_a),
    .operand_b(operand_b), .dest_register(dest_register), .busy(busy), .done(done),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        dbz;
    logic        rw;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_op(input vec_t v);
    int lat;
    logic busy_ok;
    start = 1'b1; op = v.op; operand_a = v.a; operand_b = v.b; dest_register = v.dest;
    @(negedge clk);
    start = 1'b0; op = ~v.op; operand_a = ~v.a; operand_b = ~v.b; dest_register = ~v.dest;
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy || reg_write) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32);
    chk("busy_during_run", {31'd0, busy_ok}, 1);
    chk("done", {31'd0, done}, 1);
    chk("busy_in_done", {31'd0, busy}, 0);
    chk("reg_write", {31'd0, reg_write}, {31'd0, v.rw});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, v.dbz});
    if (v.rw) begin
      chk("write_register", {27'd0, write_register}, {27'd0, v.dest});
      chk("write_data", write_data, v.data);
    end
    @(negedge clk);
    chk("done_cleared", {31'd0, done}, 0);
    chk("outputs_cleared", {write_data[31:3], reg_write, div_by_zero, |write_register}, 0);
  endtask

  initial begin
    int writes;
    vec_t v;
    vt[0] = '{2'b00, 32'd7,        32'd6,          5'd5,  32'd42,         1'b0, 1'b1};
    vt[1] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,   5'd6,  32'h00000001,   1'b0, 1'b1};
    vt[2] = '{2'b01, 32'd100,      32'd7,          5'd9,  32'd14,         1'b0, 1'b1};
    vt[3] = '{2'b10, 32'd100,      32'd7,          5'd9,  32'd2,          1'b0, 1'b1};
    vt[4] = '{2'b01, 32'h00001234, 32'd0,          5'd10, 32'hFFFFFFFF,   1'b1, 1'b1};
    vt[5] = '{2'b10, 32'h00001234, 32'd0,          5'd11, 32'h00001234,   1'b1, 1'b1};
    vt[6] = '{2'b11, 32'h00010000, 32'h00010001,   5'd12, 32'h00010000,   1'b0, 1'b1};
    vt[7] = '{2'b01, 32'hFFFFFFFF, 32'h00000010,   5'd31, 32'h0FFFFFFF,   1'b0, 1'b1};
    vt[8] = '{2'b10, 32'd5,        32'd9,          5'd1,  32'd5,          1'b0, 1'b1};
    vt[9] = '{2'b00, 32'd2,        32'd3,          5'd0,  32'd6,          1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, reg_write, div_by_zero, write_register, write_data[25:0]}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // Every vector issues its start in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < 10; i++) do_op(vt[i]);

    // start held high through RUN and DONE: exactly one write.
    start = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; dest_register = 5'd3;
    writes = 0;
    @(negedge clk);
    for (int i = 0; i < 33 && !done; i++) @(negedge clk);
    chk("held_done", {31'd0, done}, 1);
    chk("held_data", write_data, 32'd81);
    if (reg_write) writes++;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (reg_write) writes++;
      @(negedge clk);
    end
    chk("held_single_write", writes, 1);

    // Reset 10 cycles into RUN aborts without a write.
    start = 1'b1; op = 2'b00; operand_a = 32'd4; operand_b = 32'd4; dest_register = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("run_before_reset", {31'd0, busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("busy_after_reset", {31'd0, busy}, 0);
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      if (reg_write || done || busy) writes++;
      @(negedge clk);
    end
    chk("no_activity_after_abort", writes, 0);
    v = '{2'b00, 32'd3, 32'd5, 5'd2, 32'd15, 1'b0, 1'b1};
    do_op(v);

    // Reset on the edge that would finish the operation suppresses its write.
    start = 1'b1; op = 2'b00; operand_a = 32'd8; operand_b = 32'd8; dest_register = 5'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_at_finish", {29'd0, reg_write, done, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
